// File: rtl/display_bcd_mux.sv
// display_bcd_mux: latched double-dabble BCD converter driving a multiplexed seven-segment bank; DISPLAY_BCD_MUX_LZB_EN enables leading-zero blanking
module display_bcd_mux #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              ready,
  output logic [0:6]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [3:0] DASH  = 4'hE;
  localparam logic [3:0] BLANK = 4'hF;

  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [0:6] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1110011;
      DASH:    decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    bcd, adj, bcd_n;
  logic [CW-1:0]    cnt;
  logic             ovf_next, done;
  logic [3:0]       dig   [DIGITS];
  logic [3:0]       dig_n [DIGITS];
  logic [DW-1:0]    div;
  logic [IW-1:0]    idx;

  assign busy = state == CONVERT;
  assign done = busy && cnt == CW'(1);

  always_ff @(posedge clk) state <= reset ? IDLE : state_n;

  always_comb state_n = state == IDLE ? (ready ? CONVERT : IDLE) : (done ? IDLE : CONVERT);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bcd_n = BW'({adj, sh[WIDTH-1]});
  end

`ifdef DISPLAY_BCD_MUX_LZB_EN
  logic lead;

  always_comb begin
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && bcd_n[4*i +: 4] == 4'd0 && i > 0;
      dig_n[i] = ovf_next ? DASH : lead ? BLANK : bcd_n[4*i +: 4];
    end
  end
`else
  always_comb
    for (int i = 0; i < DIGITS; i++) dig_n[i] = ovf_next ? DASH : bcd_n[4*i +: 4];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      ovf      <= 1'b0;
      dig      <= '{default: 4'd0};
    end else if (state == IDLE && ready) begin
      sh       <= value;
      bcd      <= '0;
      cnt      <= CW'(WIDTH);
      ovf_next <= 64'(value) >= LIMIT;
    end else if (busy) begin
      sh  <= sh << 1;
      bcd <= bcd_n;
      cnt <= cnt - CW'(1);
      if (done) begin
        ovf <= ovf_next;
        dig <= dig_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
      an  <= '0;
      seg <= 7'b0000000;
    end else begin
      div <= div == DW'(SCAN_DIV - 1) ? '0 : div + DW'(1);
      idx <= div != DW'(SCAN_DIV - 1) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      an  <= DIGITS'(1) << idx;
      seg <= decode(dig[idx]);
    end
  end
endmodule

// File: tb/tb_display_bcd_mux.sv
// tb_display_bcd_mux: directed and random loads checked against an arithmetic model of the display
module tb_display_bcd_mux;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ready = 1'b0;
  logic [W-1:0] value = '0;
  logic [0:6]   seg;
  logic [D-1:0] an;
  logic         busy, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  logic [6:0] exp_code [D];
  logic       exp_ovf;
  logic [6:0] code_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  display_bcd_mux #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .value(value), .ready(ready),
    .seg(seg), .an(an), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    ecount = reset ? 0 : ecount + 1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    exp_ovf = 1'b0;
    for (int i = 0; i < D; i++) exp_code[i] = code_tab[0];
  endtask

  task automatic model(input int v);
    int p = 1;
    exp_ovf = v >= 10 ** D;
    for (int i = 0; i < D; i++) begin
      exp_code[i] = exp_ovf ? 7'b0000001 : code_tab[(v / p) % 10];
`ifdef DISPLAY_BCD_MUX_LZB_EN
      if (!exp_ovf && i > 0 && v < p) exp_code[i] = 7'b0000000;
`endif
      p *= 10;
    end
  endtask

  task automatic load(input int v);
    ready = 1'b1;
    value = W'(v);
    tick;
    ready = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("busy", busy, 1);
      tick;
    end
    check("busy_end", busy, 0);
    model(v);
    check("ovf", ovf, exp_ovf);
  endtask

  task automatic scan(input int n);
    for (int c = 0; c < n; c++) begin
      int ix;
      tick;
      ix = ((ecount - 1) / SD) % D;
      check("an", an, 1 << ix);
      check("seg", seg, exp_code[ix]);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      tick;
      check("rst_seg", seg, 0);
      check("rst_an", an, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
    end
    reset = 1'b0;
    tick;
    check("first_an", an, 1);
    check("first_seg", seg, code_tab[0]);
    scan(2 * SD * D - 1);

    load(13);   scan(2 * SD * D);
    load(150);  scan(2 * SD * D);
    load(99);   scan(2 * SD * D);
    load(100);  scan(SD * D);
    load(0);    scan(SD * D);
    load(7);    scan(2 * SD * D);

    ready = 1'b1;
    value = W'(5);
    tick;
    ready = 1'b0;
    check("lock_busy0", busy, 1);
    tick;
    check("lock_busy1", busy, 1);
    ready = 1'b1;
    value = W'(9);
    tick;
    ready = 1'b0;
    for (int i = 2; i < W; i++) begin
      check("lock_busy", busy, 1);
      tick;
    end
    check("lock_end", busy, 0);
    model(5);
    check("lock_ovf", ovf, exp_ovf);
    scan(2 * SD * D);

    ready = 1'b1;
    value = W'(42);
    tick;
    for (int i = 0; i < W; i++) begin
      check("held_busy", busy, 1);
      tick;
    end
    check("held_gap", busy, 0);
    value = W'(77);
    tick;
    ready = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("reload_busy", busy, 1);
      tick;
    end
    check("reload_end", busy, 0);
    model(77);
    scan(2 * SD * D);

    ready = 1'b1;
    value = W'(200);
    tick;
    ready = 1'b0;
    check("abort_busy0", busy, 1);
    tick;
    check("abort_busy1", busy, 1);
    tick;
    check("abort_busy2", busy, 1);
    reset = 1'b1;
    tick;
    check("abort_busy", busy, 0);
    check("abort_ovf", ovf, 0);
    check("abort_an", an, 0);
    check("abort_seg", seg, 0);
    reset = 1'b0;
    model_reset();
    scan(2 * SD * D);

    for (int r = 0; r < 16; r++) begin
      load(int'($urandom_range(0, (1 << W) - 1)));
      scan(SD * D + int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_bcd_mux.md
# display_bcd_mux

Parametrised successor of the two-digit seven-segment driver. It latches a binary value on a `ready`-style strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one shift per clock. It then drives a time-multiplexed bank of `DIGITS` seven-segment displays through one shared segment bus and a one-hot digit select. It sits between the encoder/arithmetic blocks and the board displays, and replaces the fixed per-code lookup table.

## Interface
- `WIDTH`, 4, width of the binary input; legal range 1..32.
- `DIGITS`, 2, number of decimal digits displayed; legal range 1..8.
- `SCAN_DIV`, 1000, clock cycles each digit stays selected; minimum 1.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  WIDTH  unsigned binary value to display.
- `ready`  in  1  load strobe; sampled on the rising edge of `clk`.
- `seg`  out  [0:6]  segments a..g, active-high. `seg[0]` = a.
- `an`  out  DIGITS  one-hot digit select. `an[0]` = least-significant (rightmost) digit.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  last loaded value exceeded 10^DIGITS − 1.

## Operation
- Controller FSM has two states: IDLE and CONVERT.
- IDLE:
  - `ready`=1 captures `value` into the shift register and clears the BCD accumulator.
  - It also latches `ovf_next` = (`value` ≥ 10^DIGITS), a compile-time constant compare.
  - Shift counter is loaded with WIDTH, and the FSM goes to CONVERT.
- CONVERT, each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, shift} is shifted left by 1 and the counter is decremented.
  - When the counter reaches 1, that cycle's result is written to the digit registers, `ovf` is updated, and the FSM returns to IDLE.
- `ready` is ignored while in CONVERT; there is no queueing.
- Overflow: every digit register holds DASH. The pattern shown is `0000001` (g only) on all digits.
- BCD accumulator width is 4·DIGITS. Bits shifted out beyond the top nibble are discarded; `ovf` covers that case.
- Segment codes, digit 0..9:
  - 0 = `1111110`, 1 = `0110000`, 2 = `1101101`, 3 = `1111001`, 4 = `0110011`
  - 5 = `1011011`, 6 = `1011111`, 7 = `1110000`, 8 = `1111111`, 9 = `1110011`
  - BLANK = `0000000`, DASH = `0000001`.
- Scanner: a free-running divider counts 0..SCAN_DIV−1. At terminal count the digit index advances, wrapping from DIGITS−1 to 0.
- Scanner is independent of the FSM. Digit registers update atomically, so a digit never shows a partial conversion.

## Timing
- Reset: `seg`=`0000000`, `an`=0, `busy`=0, `ovf`=0. All digit registers hold 0, the divider and index are 0, and the FSM is in IDLE.
- First edge after reset deasserts: `an`=one-hot(0), `seg`=code(0).
- `seg` and `an` are registered. Each reflects the index and digit registers from the previous cycle, so there is one cycle of latency.
- `ready` is sampled high at edge k:
  - `busy`=1 for cycles k+1 .. k+WIDTH.
  - Digit registers and `ovf` are valid from cycle k+WIDTH+1, when `busy`=0.
  - A new `ready` is accepted at edge k+WIDTH+1 at the earliest.
- Cycle k+WIDTH+1 is IDLE, so `ready` held high reloads back-to-back, once every WIDTH+1 cycles.
- Reset asserted mid-conversion: conversion aborts and all reset values apply. Digit registers return to 0, not to the previous value.
- DIGITS=1: `an` stays at 1 and the divider still runs.
- SCAN_DIV=1: the index advances every cycle.

## Configuration
- Macro: `DISPLAY_BCD_MUX_LZB_EN`.
- Defined: leading-zero blanking. Every digit above the most-significant non-zero digit shows BLANK.
  - Digit 0 is never blanked, so value 0 shows a single `1111110`.
  - Overflow DASH takes priority over blanking.
- Undefined: all DIGITS digits always show their numeric code, including leading zeros.

## Test plan
- Reset: hold `reset` for 3 cycles, then release.
  - During reset: `seg`=`0000000`, `an`=0, `busy`=0, `ovf`=0.
  - One cycle after release: `an`=01, `seg`=`1111110`.
- Conversion, WIDTH=4, DIGITS=2, SCAN_DIV=4: pulse `ready` with `value`=13.
  - `busy` is high exactly 4 cycles, and `ovf`=0.
  - Display scans `an`=01/`seg`=`1111001` and `an`=10/`seg`=`0110000`, each for 4 cycles.
- Overflow, WIDTH=8, DIGITS=2: load 150.
  - `ovf`=1 and both digits show `0000001`.
  - Loading 99 afterwards clears `ovf` and both digits show `1110011`.
- Busy lockout: load 5, then pulse `ready` with `value`=9 two cycles later.
  - The second strobe is ignored and the display shows 05.
  - A strobe at k+WIDTH+1 is accepted.
- Reset mid-conversion, WIDTH=8: assert `reset` on the 3rd busy cycle.
  - `busy`=0 next cycle and the digits read 00.
- Blanking, DIGITS=3: load 7.
  - With `DISPLAY_BCD_MUX_LZB_EN`: `an`=100 and `an`=010 show `0000000`, `an`=001 shows `1110000`.
  - Without the macro: the upper digits show `1111110`.
